// File: rtl/mcp3008_scanner.sv
// mcp3008_scanner: SPI master that round-robins the MCP3008 over the channels in CH_MASK
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   enable               level, 1 = keep scanning
//   ad_clk, cs_n, din    SPI SCLK (idle low), chip select (active low), MOSI
//   dout                 MISO, already synchronised to clk
//   sample_data/ch/valid latest conversion, its channel, 1-clk update pulse
//   scan_data            channel n result at bits [10n+9:10n]
//   scan_done            1-clk pulse when the highest enabled channel completes
//   busy                 1 from the start of a frame until the end of its gap
module mcp3008_scanner #(
    parameter int unsigned CLK_DIV    = 25,
    parameter logic [7:0]  CH_MASK    = 8'hFF,
    parameter int unsigned GAP_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        ad_clk,
    output logic        cs_n,
    output logic        din,
    input  logic        dout,
    output logic [9:0]  sample_data,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic [79:0] scan_data,
    output logic        scan_done,
    output logic        busy
);
    // First enabled channel at or after 'from', wrapping past channel 7.
    function automatic logic [2:0] next_set(input logic [2:0] from);
        logic [2:0] r;
        r = from;
        for (int i = 7; i >= 0; i--)
            if (CH_MASK[from + 3'(i)]) r = from + 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] highest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    localparam logic [2:0]  LO      = next_set(3'd0);
    localparam logic [2:0]  HI      = highest(CH_MASK);
    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int          CW      = $clog2(CNT_MAX);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    half;
    logic [9:0]    shreg;
    logic [2:0]    ch;
    logic [2:0]    slot;
    logic [4:0]    cmd;
    logic          div_end, gap_end, shift_end;

    assign div_end   = cnt == CW'(CLK_DIV - 1);
    assign gap_end   = cnt == CW'(GAP_CYCLES - 1);
    assign shift_end = state == SHIFT && half == 6'd33 && div_end;
    assign cmd       = {2'b11, ch};
    // Half-periods are numbered from 0 (first high phase); din is updated at the
    // start of each odd (low) half, so halves 2k-1 and 2k carry command bit k.
    assign slot      = 3'((half + 6'd1) >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cs_n      = 1'b1;
        ad_clk    = 1'b0;
        din       = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE:  if (enable && CH_MASK != 8'd0) state_nxt = SETUP;
            SETUP: begin
                cs_n = 1'b0;
                din  = 1'b1;
                if (div_end) state_nxt = SHIFT;
            end
            SHIFT: begin
                cs_n   = 1'b0;
                ad_clk = !half[0];
                din    = half < 6'd9 && cmd[3'd4 - slot];
                if (half == 6'd33 && div_end) state_nxt = GAP;
            end
            GAP:   if (gap_end) state_nxt = enable ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            half         <= 6'd0;
            shreg        <= 10'd0;
            ch           <= LO;
            sample_data  <= 10'd0;
            sample_ch    <= 3'd0;
            sample_valid <= 1'b0;
            scan_data    <= 80'd0;
            scan_done    <= 1'b0;
        end else begin
            cnt          <= (state == IDLE || state_nxt != state || (state == SHIFT && div_end)) ? '0 : cnt + 1'b1;
            half         <= (state == SHIFT) ? half + 6'(div_end) : 6'd0;
            // Entering even halves 14..32 is rising edge 8..17 (B9..B0); edge 7 is the null bit.
            if (state == SHIFT && div_end && half[0] && half >= 6'd13)
                shreg <= {shreg[8:0], dout};
            sample_valid <= shift_end;
            scan_done    <= shift_end && ch == HI;
            if (shift_end) begin
                sample_data          <= shreg;
                sample_ch            <= ch;
                scan_data[10*ch +: 10] <= shreg;
            end
            if (state == GAP && gap_end) ch <= next_set(ch + 3'd1);
        end
    end
endmodule

// File: tb/tb_mcp3008_scanner.sv
`timescale 1ns/1ps
module tb_mcp3008_scanner;
    localparam int         CLK_DIV = 25;
    localparam int         GAP     = 50;
    localparam logic [7:0] MASK    = 8'hA2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        dout = 1'b1;
    logic        ad_clk, cs_n, din, sample_valid, scan_done, busy;
    logic [9:0]  sample_data;
    logic [2:0]  sample_ch;
    logic [79:0] scan_data;
    logic        z_ad_clk, z_cs_n, z_din, z_valid, z_done, z_busy;
    logic [9:0]  z_data;
    logic [2:0]  z_ch;
    logic [79:0] z_scan;

    int          total = 0, bad = 0;
    int          cyc = 0, t_fall = 0, prev_fall = -1, ncs = 0, nvalid = 0, redge = 0;
    int          v0, c0;
    bit          idle_seen = 1'b1, din_tail = 1'b0;
    logic [4:0]  cmdbits = 5'd0;
    logic [9:0]  word = 10'd0;
    logic [9:0]  adc_val [8];
    logic [2:0]  ptr = 3'd1;
    logic [12:0] e_ent;
    logic [12:0] q [$];

    always #10 clk = ~clk;

    mcp3008_scanner #(.CLK_DIV(CLK_DIV), .CH_MASK(MASK), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ad_clk(ad_clk), .cs_n(cs_n), .din(din),
        .dout(dout), .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .scan_data(scan_data), .scan_done(scan_done), .busy(busy)
    );

    mcp3008_scanner #(.CLK_DIV(CLK_DIV), .CH_MASK(8'h00), .GAP_CYCLES(GAP)) dut_none (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ad_clk(z_ad_clk), .cs_n(z_cs_n), .din(z_din),
        .dout(1'b0), .sample_data(z_data), .sample_ch(z_ch), .sample_valid(z_valid),
        .scan_data(z_scan), .scan_done(z_done), .busy(z_busy)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] nxt(input logic [2:0] p);
        logic [2:0] r;
        r = p + 3'd1;
        while (!MASK[r]) r = r + 3'd1;
        return r;
    endfunction

    task automatic wait_valid(input string tag);
        int n0 = nvalid;
        for (int i = 0; i < 2000 && nvalid == n0; i++) @(negedge clk);
        total++;
        assert (nvalid > n0) else begin
            bad++;
            $error("FAIL %s: sample_valid count got %0d want >%0d", tag, nvalid, n0);
        end
    endtask

    task automatic wait_cs(input string tag);
        int n0 = ncs;
        for (int i = 0; i < 2000 && ncs == n0; i++) @(negedge clk);
        total++;
        assert (ncs > n0) else begin
            bad++;
            $error("FAIL %s: cs_n fall count got %0d want >%0d", tag, ncs, n0);
        end
    endtask

    // Frame timing and scoreboard push at the start of every frame.
    always @(posedge clk) begin
        cyc++;
        if (busy === 1'b0) idle_seen = 1'b1;
    end

    always @(negedge cs_n) if (rst_n === 1'b1) begin
        ncs++;
        if (prev_fall >= 0 && !idle_seen) chk("cs_period", 80'(cyc - prev_fall), 80'(35 * CLK_DIV + GAP));
        prev_fall = cyc;
        t_fall    = cyc;
        idle_seen = 1'b0;
        redge     = 0;
        din_tail  = 1'b0;
        q.push_back({ptr, adc_val[ptr]});
    end

    always @(posedge cs_n) if (rst_n === 1'b1) begin
        chk("cs_low", 80'(cyc - t_fall), 80'(35 * CLK_DIV));
        chk("sclk_edges", 80'(redge), 80'd17);
        chk("din_tail", 80'(din_tail), 80'd0);
    end

    // ADC model: reads the command on rising edges, drives MISO on falling edges.
    always @(posedge ad_clk) begin
        redge++;
        if (redge <= 5) cmdbits = {cmdbits[3:0], din};
        else if (din) din_tail = 1'b1;
        if (redge == 5) begin
            word = adc_val[cmdbits[2:0]];
            chk("cmd_bits", 80'(cmdbits), 80'({2'b11, ptr}));
        end
    end

    always @(negedge ad_clk) dout = (redge >= 7 && redge <= 16) ? word[4'(16 - redge)] : 1'b1;

    always @(negedge clk) if (rst_n === 1'b1 && (sample_valid === 1'b1 || scan_done === 1'b1)) begin
        nvalid++;
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL unexpected_sample: got ch %0d data %h, want no pulse", sample_ch, sample_data);
        end
        if (q.size() > 0) begin
            e_ent = q.pop_front();
            chk("sample_ch", 80'(sample_ch), 80'(e_ent[12:10]));
            chk("sample_data", 80'(sample_data), 80'(e_ent[9:0]));
            chk("scan_slice", 80'(scan_data[10*e_ent[12:10] +: 10]), 80'(e_ent[9:0]));
            chk("scan_done", 80'(scan_done), 80'(e_ent[12:10] == 3'd7));
            chk("valid_pulse", 80'(sample_valid), 80'd1);
            chk("gap_cs_n", 80'(cs_n), 80'd1);
            ptr = nxt(ptr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 8; i++) adc_val[i] = 10'h000;
        adc_val[1] = 10'h001;
        adc_val[5] = 10'h3FF;
        adc_val[7] = 10'h000;
        repeat (3) @(negedge clk);
        chk("rst_ad_clk", 80'(ad_clk), 80'd0);
        chk("rst_cs_n", 80'(cs_n), 80'd1);
        chk("rst_din", 80'(din), 80'd0);
        chk("rst_sample_data", 80'(sample_data), 80'd0);
        chk("rst_sample_ch", 80'(sample_ch), 80'd0);
        chk("rst_sample_valid", 80'(sample_valid), 80'd0);
        chk("rst_scan_data", scan_data, 80'd0);
        chk("rst_scan_done", 80'(scan_done), 80'd0);
        chk("rst_busy", 80'(busy), 80'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 80'(busy), 80'd0);
        chk("idle_cs_n", 80'(cs_n), 80'd1);
        enable = 1'b1;
        @(negedge clk);
        chk("start_cs_n", 80'(cs_n), 80'd0);
        chk("start_busy", 80'(busy), 80'd1);
        // Scan order 1,5,7,1,5,7 with code changes between passes.
        wait_valid("f_ch1");
        adc_val[1] = 10'h2A5;
        wait_valid("f_ch5");
        wait_valid("f_ch7");
        adc_val[7] = 10'h3FF;
        wait_valid("f_ch1b");
        wait_valid("f_ch5b");
        wait_valid("f_ch7b");
        @(negedge clk);
        chk("scan_ch1", 80'(scan_data[19:10]), 80'h2A5);
        chk("scan_ch5", 80'(scan_data[59:50]), 80'h3FF);
        chk("scan_ch7", 80'(scan_data[79:70]), 80'h3FF);
        chk("none_busy", 80'(z_busy), 80'd0);
        chk("none_cs_n", 80'(z_cs_n), 80'd1);
        chk("none_valid", 80'(z_valid), 80'd0);
        // Drop enable in SHIFT period 4: frame completes, then idle.
        wait_cs("drop_cs");
        c0 = ncs;
        repeat (CLK_DIV + 6 * CLK_DIV + 5) @(negedge clk);
        enable = 1'b0;
        v0 = nvalid;
        wait_valid("drop_frame");
        repeat (GAP + 3) @(negedge clk);
        chk("drop_busy", 80'(busy), 80'd0);
        chk("drop_cs_n", 80'(cs_n), 80'd1);
        repeat (200) @(negedge clk);
        chk("drop_pulses", 80'(nvalid - v0), 80'd1);
        chk("drop_no_frame", 80'(ncs - c0), 80'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_cs_n", 80'(cs_n), 80'd0);
        wait_valid("reen_frame");
        // Reset in SHIFT period 10 of the channel-7 frame.
        wait_cs("rst_cs");
        repeat (CLK_DIV + 18 * CLK_DIV + 5) @(negedge clk);
        #3 rst_n = 1'b0;
        q.delete();
        ptr = 3'd1;
        #1;
        chk("arst_cs_n", 80'(cs_n), 80'd1);
        chk("arst_ad_clk", 80'(ad_clk), 80'd0);
        chk("arst_scan", scan_data, 80'd0);
        chk("arst_busy", 80'(busy), 80'd0);
        chk("arst_valid", 80'(sample_valid), 80'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("after_rst");
        chk("after_rst_scan", scan_data, 80'(10'h2A5) << 10);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
